if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Pipelined instruction-fetch stage: owns the PC and issues word reads to instruction memory
//  over a req/ack handshake. Presents {instr, pc, pc+4} to decode through an IF/ID register
//  with a one-entry skid buffer. Feeds BR / Unidad_control / Sign_Ext / ControladorALU.
//  Accepts a branch redirect from the branch Add/AND path downstream.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset (bits [1:0] must be 0)
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  rst          in   1   asynchronous, active-high reset
//  imem_req     out  1   read request to instruction memory
//  imem_addr    out  32  word-aligned read address, stable while imem_req=1
//  imem_ack     in   1   memory accepts request; imem_rdata valid this cycle
//  imem_rdata   in   32  instruction word
//  redirect     in   1   taken branch: flush and fetch from redirect_pc
//  redirect_pc  in   32  branch target; bits [1:0] ignored (forced 0)
//  id_ready     in   1   decode accepts IF/ID this cycle (0 = stall)
//  id_valid     out  1   IF/ID register holds a valid instruction
//  id_instr     out  32  instruction to decode
//  id_pc        out  32  address of id_instr
//  id_pc4       out  32  id_pc + 4
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, imem_req=0, id_valid=0, id_instr/id_pc/id_pc4=0, buffer empty.
//  Handshake: transfer when imem_req&&imem_ack (0..n wait cycles). Once raised, imem_req stays 1
//   and imem_addr stays constant until ack; a request is never withdrawn.
//  Decode side: IF/ID consumed when id_valid&&id_ready.
//  States (imem_req=1 in FETCH and DROP only):
//   IDLE : -> FETCH next cycle unconditionally (first req 1 cycle after reset release).
//   FETCH: imem_addr=pc. No ack: wait. redirect w/o ack -> DROP, pend_pc<=redirect_pc.
//    ack & redirect same cycle: discard rdata, pc<=redirect_pc, stay FETCH.
//    ack, IF/ID free or consumed this cycle: load IF/ID {rdata,pc,pc+4}, pc<=pc+4, stay FETCH.
//    ack, IF/ID full and not consumed: rdata -> skid buffer, pc<=pc+4, -> HOLD.
//   HOLD : imem_req=0. When IF/ID consumed: buffer -> IF/ID, -> FETCH.
//   DROP : imem_req=1 with OLD address. redirect here overwrites pend_pc (last one wins).
//    On ack: discard rdata, pc<=pend_pc, -> FETCH.
//  Redirect: highest priority after reset in every state.
//   Same cycle: id_valid<=0, buffer cleared, no instruction on the wrong path ever reaches IF/ID.
//   HOLD+redirect: pc<=redirect_pc, -> FETCH. IDLE+redirect: pc<=redirect_pc, -> FETCH.
//  Throughput: 1 instr/cycle with zero-wait ack and id_ready=1; latency req->id_valid = 1 cycle.
//  Arithmetic: pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0). id_pc4 is also computed mod 2^32.
//  IF/ID and buffer hold values stable while stalled.
//  Reset mid-operation (any state, incl. DROP with request outstanding) returns to reset values;
//   the memory's in-flight response is not tracked after reset.
// TESTING
//  1 Reset release, RESET_PC=0, ack tied 1, id_ready=1 -> imem_req rises cycle 1; id_pc = 0,4,8,... one per cycle.
//  2 ack delayed 3 cycles on addr 0x10 -> imem_addr=0x10 held 4 cycles; id_valid pulses once, id_pc=0x10.
//  3 id_ready=0 for 5 cycles -> state HOLD, imem_req=0, IF/ID frozen; id_ready=1 -> buffered instr next, no loss/dup.
//  4 redirect(0x200) while request to 0x40 waits -> DROP, addr stays 0x40; after ack next addr 0x200, 0x40 data never on id_*.
//  5 redirect(0x300) on same cycle as ack -> rdata discarded, id_valid=0 next cycle, next imem_addr=0x300.
//  6 redirect_pc=0xFFFF_FFFE -> fetch 0xFFFF_FFFC, id_pc4=0, next addr 0x0; rst asserted in DROP -> all outputs reset.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over a req/ack handshake
// and delivers {instr, pc, pc+4} to decode through an IF/ID register backed by a one-entry skid buffer.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DROP
    } state_t;

    localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] pend_pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic [31:0] target;
    logic        consume;

    // pc only changes on a completed transfer, so it doubles as the stable request address
    assign imem_addr = pc;
    assign pc4       = pc + 32'd4;
    assign target    = redirect_pc & 32'hFFFF_FFFC;
    assign consume   = id_valid && id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_ADDR;
            pend_pc   <= RESET_ADDR;
            imem_req  <= 1'b0;
            id_valid  <= 1'b0;
            id_instr  <= '0;
            id_pc     <= '0;
            id_pc4    <= '0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else if (redirect) begin
            // Wrong-path data is never loaded; leaving HOLD implicitly empties the buffer
            id_valid <= 1'b0;
            imem_req <= 1'b1;
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        pc    <= target;
                        state <= FETCH;
                    end else begin
                        pend_pc <= target;
                        state   <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        pc    <= target;
                        state <= FETCH;
                    end else begin
                        pend_pc <= target;
                        state   <= DROP;
                    end
                end
                default: begin
                    pc    <= target;
                    state <= FETCH;
                end
            endcase
        end else begin
            if (consume) begin
                id_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        pc <= pc4;
                        if (!id_valid || id_ready) begin
                            id_valid <= 1'b1;
                            id_instr <= imem_rdata;
                            id_pc    <= pc;
                            id_pc4   <= pc4;
                        end else begin
                            buf_instr <= imem_rdata;
                            buf_pc    <= pc;
                            state     <= HOLD;
                            imem_req  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        id_valid <= 1'b1;
                        id_instr <= buf_instr;
                        id_pc    <= buf_pc;
                        id_pc4   <= buf_pc + 32'd4;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        pc    <= pend_pc;
                        state <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run scored
// against an in-order delivery model of the instruction stream.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    int errors;
    int checks;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc4(id_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // Advance one cycle; memory always presents the word at the current address
    task automatic tick;
        @(posedge clk);
        #1;
        imem_rdata = mem_word(imem_addr);
    endtask

    task automatic apply_reset;
        rst = 1'b1; imem_ack = 1'b0; id_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        imem_rdata = mem_word(imem_addr);
    endtask

    task automatic run_to(input logic [31:0] a);
        int n;
        n = 0;
        while (imem_addr !== a && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (imem_addr !== a) begin
            errors++;
            $display("FAIL run_to timeout addr=%h want=%h", imem_addr, a);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; imem_ack = 1'b1; id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
        tick;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        checks++; if ({id_instr, id_pc, id_pc4} !== 96'h0) begin errors++; $display("FAIL reset_id got=%h/%h/%h exp=0", id_instr, id_pc, id_pc4); end
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, RESET_PC); end
        redirect = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        tick;
        checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL first_req got=%b/%h exp=1/%h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_stream;
        logic [31:0] e;
        apply_reset;
        imem_ack = 1'b1; id_ready = 1'b1;
        tick;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req got=%b exp=1", imem_req); end
        for (int k = 0; k < 8; k++) begin
            tick;
            e = 32'(k) * 32'd4;
            checks++;
            if (id_valid !== 1'b1 || id_pc !== e || id_instr !== mem_word(e) || id_pc4 !== e + 32'd4) begin
                errors++;
                $display("FAIL stream_%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", k, id_valid, id_pc, id_instr, id_pc4, e, mem_word(e), e + 32'd4);
            end
        end
    endtask

    task automatic test_wait;
        apply_reset;
        imem_ack = 1'b1; id_ready = 1'b1;
        tick;
        run_to(32'h10);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL wait_hold_%0d got=%b/%h exp=1/00000010", i, imem_req, imem_addr); end
            if (i > 0) begin
                checks++;
                if (id_valid !== 1'b0) begin errors++; $display("FAIL wait_idle_%0d got=%b exp=0", i, id_valid); end
            end
            imem_ack = (i == 3);
            tick;
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_instr !== mem_word(32'h10)) begin
            errors++; $display("FAIL wait_deliver got=%b/%h/%h exp=1/00000010/%h", id_valid, id_pc, id_instr, mem_word(32'h10));
        end
        imem_ack = 1'b0;
        tick;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL wait_pulse got=%b exp=0", id_valid); end
    endtask

    task automatic test_stall;
        logic [31:0] x;
        apply_reset;
        imem_ack = 1'b1; id_ready = 1'b1;
        repeat (4) tick;
        x = id_pc;
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++;
            if (id_valid !== 1'b1 || id_pc !== x || id_instr !== mem_word(x) || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_%0d got=%b/%h/%h req=%b exp=1/%h/%h req=0", i, id_valid, id_pc, id_instr, imem_req, x, mem_word(x));
            end
        end
        id_ready = 1'b1;
        tick;
        checks++;
        if (id_pc !== x + 32'd4 || id_instr !== mem_word(x + 32'd4) || imem_req !== 1'b1 || imem_addr !== x + 32'd8) begin
            errors++; $display("FAIL stall_resume got=%h/%h/%b/%h exp=%h/%h/1/%h", id_pc, id_instr, imem_req, imem_addr, x + 32'd4, mem_word(x + 32'd4), x + 32'd8);
        end
        tick;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== x + 32'd8) begin errors++; $display("FAIL stall_next got=%b/%h exp=1/%h", id_valid, id_pc, x + 32'd8); end
    endtask

    task automatic test_drop;
        apply_reset;
        imem_ack = 1'b1; id_ready = 1'b1;
        tick;
        run_to(32'h40);
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
        tick;
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h40 || id_valid !== 1'b0) begin
                errors++; $display("FAIL drop_hold_%0d got=%b/%h/%b exp=1/00000040/0", i, imem_req, imem_addr, id_valid);
            end
            if (i == 2) imem_ack = 1'b1;
            tick;
        end
        checks++;
        if (imem_addr !== 32'h200 || id_valid !== 1'b0) begin errors++; $display("FAIL drop_target got=%h/%b exp=00000200/0", imem_addr, id_valid); end
        tick;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== mem_word(32'h200)) begin
            errors++; $display("FAIL drop_deliver got=%b/%h/%h exp=1/00000200/%h", id_valid, id_pc, id_instr, mem_word(32'h200));
        end
    endtask

    task automatic test_redirect_ack;
        apply_reset;
        imem_ack = 1'b1; id_ready = 1'b1;
        tick;
        run_to(32'h20);
        redirect = 1'b1; redirect_pc = 32'h300;
        tick;
        redirect = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h300 || imem_req !== 1'b1) begin
            errors++; $display("FAIL redir_ack got=%b/%h/%b exp=0/00000300/1", id_valid, imem_addr, imem_req);
        end
        tick;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_instr !== mem_word(32'h300)) begin
            errors++; $display("FAIL redir_deliver got=%b/%h/%h exp=1/00000300/%h", id_valid, id_pc, id_instr, mem_word(32'h300));
        end
    endtask

    task automatic test_wrap_reset;
        apply_reset;
        imem_ack = 1'b1; id_ready = 1'b1;
        tick;
        run_to(32'h8);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick;
        redirect = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
        tick;
        checks++;
        if (id_pc !== 32'hFFFF_FFFC || id_pc4 !== 32'h0 || imem_addr !== 32'h0 || id_instr !== mem_word(32'hFFFF_FFFC)) begin
            errors++; $display("FAIL wrap_deliver got=%h/%h/%h exp=fffffffc/00000000/00000000", id_pc, id_pc4, imem_addr);
        end
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h500;
        tick;
        redirect = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_drop got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || id_valid !== 1'b0 || {id_instr, id_pc, id_pc4} !== 96'h0 || imem_addr !== RESET_PC) begin
            errors++; $display("FAIL drop_reset got=%b/%b/%h/%h/%h/%h exp=0/0/0/0/0/%h", imem_req, id_valid, id_instr, id_pc, id_pc4, imem_addr, RESET_PC);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; imem_ack = 1'b1;
        imem_rdata = mem_word(imem_addr);
        tick;
        tick;
        checks++;
        if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin errors++; $display("FAIL post_reset got=%b/%h exp=1/%h", id_valid, id_pc, RESET_PC); end
    endtask

    task automatic test_random;
        localparam int N = 2000;
        logic [31:0] exp_next;
        logic        p_req, p_ack, p_valid, p_ready, p_redir;
        logic [31:0] p_addr, p_instr, p_pc, p_pc4;
        int          delivered;
        int          gap;
        apply_reset;
        exp_next = RESET_PC;
        delivered = 0;
        gap = 0;
        p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_ready = 1'b0; p_redir = 1'b0;
        p_addr = '0; p_instr = '0; p_pc = '0; p_pc4 = '0;
        for (int cyc = 0; cyc < N; cyc++) begin
            if (p_req && !p_ack) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                    errors++; $display("FAIL rnd_req_stable cyc=%0d got=%b/%h exp=1/%h", cyc, imem_req, imem_addr, p_addr);
                end
            end
            if (p_valid && !p_ready && !p_redir) begin
                checks++;
                if (id_valid !== 1'b1 || {id_instr, id_pc, id_pc4} !== {p_instr, p_pc, p_pc4}) begin
                    errors++; $display("FAIL rnd_id_stable cyc=%0d got=%b/%h/%h exp=1/%h/%h", cyc, id_valid, id_pc, id_instr, p_pc, p_instr);
                end
            end
            if (imem_req) begin
                checks++;
                if (imem_addr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_align cyc=%0d got=%h", cyc, imem_addr); end
            end
            imem_ack = ($urandom_range(0, 99) < 60);
            id_ready = ($urandom_range(0, 99) < 70);
            redirect = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else redirect_pc = $urandom;
            if (redirect) begin
                exp_next = redirect_pc & 32'hFFFF_FFFC;
            end else if (id_valid && id_ready) begin
                checks++;
                if (id_pc !== exp_next || id_instr !== mem_word(exp_next) || id_pc4 !== exp_next + 32'd4) begin
                    errors++; $display("FAIL rnd_deliver cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, id_pc, id_instr, id_pc4, exp_next, mem_word(exp_next), exp_next + 32'd4);
                end
                exp_next = exp_next + 32'd4;
                delivered++;
                gap = 0;
            end
            gap++;
            if (gap > 150) begin
                checks++; errors++;
                $display("FAIL rnd_progress cyc=%0d no delivery for %0d cycles", cyc, gap);
                break;
            end
            p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
            p_valid = id_valid; p_ready = id_ready; p_redir = redirect;
            p_instr = id_instr; p_pc = id_pc; p_pc4 = id_pc4;
            tick;
        end
        redirect = 1'b0;
        checks++;
        if (delivered < N / 8) begin errors++; $display("FAIL rnd_throughput got=%0d exp>=%0d", delivered, N / 8); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1; imem_ack = 1'b0; id_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0; imem_rdata = '0;
        test_reset;
        test_stream;
        test_wait;
        test_stall;
        test_drop;
        test_redirect_ack;
        test_wrap_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
